// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and helpers for the oversampling UART receiver
package uart_pkg;

    localparam int MAX_DATA_BITS = 9;

    typedef enum logic [1:0] {
        PAR_NONE = 2'd0,
        PAR_ODD  = 2'd1,
        PAR_EVEN = 2'd2
    } parity_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } rx_state_t;

    typedef struct packed {
        logic [MAX_DATA_BITS-1:0] data;
        logic                     perr;
        logic                     ferr;
    } rx_word_t;

    // Clocks per oversample tick, truncated.
    function automatic int calc_div(input int clk_freq, input int baud_rate, input int oversample);
        return clk_freq / (baud_rate * oversample);
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - small synchronous FIFO holding received words
module uart_rx_fifo #(
    parameter int WIDTH = 11,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    output logic             full,
    input  logic             pop,
    output logic             valid,
    output logic [WIDTH-1:0] head
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign valid   = (count != '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_pop  = pop & valid;
    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    assign do_push = push & (~full | do_pop);
    assign head    = valid ? mem[rptr] : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) begin
                wptr <= wptr + 1'b1;
            end
            if (do_pop) begin
                rptr <= rptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wptr] <= push_data;
        end
    end

endmodule

// File: rtl/uart_rx_os.sv
// rtl/uart_rx_os.sv - oversampling UART receiver with majority vote, error flags and output FIFO
module uart_rx_os
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 50000000,
    parameter int BAUD_RATE  = 9600,
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] m_data,
    output logic                 m_parity_err,
    output logic                 m_frame_err,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic                 overrun,
    output logic                 busy
);

    localparam int      DIV      = calc_div(CLK_FREQ, BAUD_RATE, OVERSAMPLE);
    localparam int      TW       = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int      SW       = $clog2(OVERSAMPLE);
    localparam int      M        = OVERSAMPLE / 2;
    localparam parity_t PAR_MODE = parity_t'(PARITY);

    localparam logic [SW-1:0] SC_A    = SW'(M - 1);
    localparam logic [SW-1:0] SC_B    = SW'(M);
    localparam logic [SW-1:0] SC_V    = SW'(M + 1);
    localparam logic [SW-1:0] SC_LAST = SW'(OVERSAMPLE - 1);

    if (DIV < 1) begin : g_div_err
        $error("uart_rx_os: CLK_FREQ too low for BAUD_RATE*OVERSAMPLE");
    end
    if ((OVERSAMPLE < 8) || (OVERSAMPLE % 2 != 0)) begin : g_os_err
        $error("uart_rx_os: OVERSAMPLE must be even and at least 8");
    end
    if ((DATA_BITS < 5) || (DATA_BITS > MAX_DATA_BITS)) begin : g_db_err
        $error("uart_rx_os: DATA_BITS must be 5..9");
    end
    if ((PARITY < 0) || (PARITY > 2) || (STOP_BITS < 1) || (STOP_BITS > 2)) begin : g_fmt_err
        $error("uart_rx_os: PARITY must be 0..2 and STOP_BITS 1..2");
    end
    if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_fifo_err
        $error("uart_rx_os: FIFO_DEPTH must be a power of two, at least 2");
    end

    rx_state_t       state;
    rx_state_t       state_next;
    logic            rx_meta;
    logic            rx_s;
    logic            rx_prev;
    logic            start_edge;
    logic [TW-1:0]   tick_cnt;
    logic            tick;
    logic [SW-1:0]   sc;
    logic [1:0]      samp;
    logic            vote;
    logic            vote_now;
    logic            bit_end;
    logic [3:0]      bit_idx;
    logic            stop_idx;
    logic            last_data;
    logic            last_stop;
    logic [MAX_DATA_BITS-1:0] shreg;
    logic            perr;
    logic            ferr;
    logic            exp_par;
    logic            push;
    logic            fifo_full;
    rx_word_t        push_word;
    rx_word_t        head_word;
    logic            unused_head;

    // rx_prev trails rx_s so a falling edge is seen even right after a frame ends.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
            rx_prev <= rx_s;
        end
    end

    assign start_edge = (state == ST_IDLE) & rx_prev & ~rx_s;
    assign tick       = (tick_cnt == TW'(DIV - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_cnt <= '0;
        end else if (start_edge || tick) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + 1'b1;
        end
    end

    assign vote      = (samp[0] & samp[1]) | (samp[0] & rx_s) | (samp[1] & rx_s);
    assign vote_now  = tick & (state != ST_IDLE) & (sc == SC_V);
    assign bit_end   = tick & (sc == SC_LAST);
    assign last_data = (bit_idx == 4'(DATA_BITS - 1));
    assign last_stop = (STOP_BITS == 1) | stop_idx;
    assign exp_par   = (PAR_MODE == PAR_ODD) ? ~(^shreg) : ^shreg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        push       = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start_edge) begin
                    state_next = ST_START;
                end
            end
            ST_START: begin
                if (vote_now && vote) begin
                    state_next = ST_IDLE;
                end else if (bit_end) begin
                    state_next = ST_DATA;
                end
            end
            ST_DATA: begin
                if (bit_end && last_data) begin
                    state_next = (PAR_MODE != PAR_NONE) ? ST_PARITY : ST_STOP;
                end
            end
            ST_PARITY: begin
                if (bit_end) begin
                    state_next = ST_STOP;
                end
            end
            ST_STOP: begin
                // Leave mid-bit so a following start edge is not missed.
                if (vote_now && last_stop) begin
                    push       = 1'b1;
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sc       <= '0;
            samp     <= 2'b11;
            bit_idx  <= '0;
            stop_idx <= 1'b0;
            shreg    <= '0;
            perr     <= 1'b0;
            ferr     <= 1'b0;
        end else if (state == ST_IDLE) begin
            if (start_edge) begin
                sc       <= '0;
                bit_idx  <= '0;
                stop_idx <= 1'b0;
                shreg    <= '0;
                perr     <= 1'b0;
                ferr     <= 1'b0;
            end
        end else if (tick) begin
            sc <= (sc == SC_LAST) ? '0 : sc + 1'b1;
            if (sc == SC_A) begin
                samp[0] <= rx_s;
            end
            if (sc == SC_B) begin
                samp[1] <= rx_s;
            end
            if (sc == SC_V) begin
                case (state)
                    ST_DATA:   shreg[bit_idx] <= vote;
                    ST_PARITY: perr <= (vote != exp_par);
                    ST_STOP:   ferr <= ferr | ~vote;
                    default:   ;
                endcase
            end
            if (sc == SC_LAST) begin
                case (state)
                    ST_DATA: bit_idx  <= bit_idx + 1'b1;
                    ST_STOP: stop_idx <= ~stop_idx;
                    default: ;
                endcase
            end
        end
    end

    // The final stop-bit vote is folded in directly since ferr updates on the same edge.
    assign push_word = '{data: shreg, perr: perr, ferr: ferr | ~vote};

    uart_rx_fifo #(
        .WIDTH ($bits(rx_word_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (push_word),
        .full      (fifo_full),
        .pop       (m_ready),
        .valid     (m_valid),
        .head      (head_word)
    );

    assign m_data       = head_word.data[DATA_BITS-1:0];
    assign m_parity_err = head_word.perr;
    assign m_frame_err  = head_word.ferr;
    assign overrun      = push & fifo_full & ~(m_valid & m_ready);
    assign busy         = (state != ST_IDLE);
    assign unused_head  = ^head_word;

endmodule

// File: tb/tb_uart_rx_os.sv
// tb/tb_uart_rx_os.sv - self-checking bench for uart_rx_os across three frame formats
`timescale 1ns/1ps
module tb_uart_rx_os;

    localparam int CLKF  = 1600000;
    localparam int BAUD  = 100000;
    localparam int OS    = 16;
    localparam int BIT   = 16;
    localparam int DEPTH = 4;
    localparam int NI    = 3;

    typedef struct packed {
        logic [8:0] d;
        logic       pe;
        logic       fe;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx [NI];
    logic       rdy [NI];
    logic       rdy_set [NI];
    logic       rand_rdy = 1'b0;
    wire  [8:0] mdata [NI];
    wire        mv [NI];
    wire        mpe [NI];
    wire        mfe [NI];
    wire        ovr [NI];
    wire        bsy [NI];
    wire  [7:0] md_a;
    wire  [7:0] md_p;
    wire  [6:0] md_s;

    exp_t       q0[$];
    exp_t       q1[$];
    exp_t       q2[$];
    int         checks = 0;
    int         failures = 0;
    int         exp_ovr [NI];
    int         ovr_cnt [NI];
    int         pops [NI];
    logic [8:0] last_d [NI];
    logic       last_pe [NI];
    logic       last_fe [NI];
    logic       hold_prev [NI];
    logic [10:0] hold_word [NI];

    assign mdata[0] = {1'b0, md_a};
    assign mdata[1] = {1'b0, md_p};
    assign mdata[2] = {2'b00, md_s};

    always #5 clk = ~clk;

    uart_rx_os #(.CLK_FREQ(CLKF), .BAUD_RATE(BAUD), .OVERSAMPLE(OS), .DATA_BITS(8),
                 .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(DEPTH)) dut_a (
        .clk(clk), .rst_n(rst_n), .rx(rx[0]), .m_data(md_a), .m_parity_err(mpe[0]),
        .m_frame_err(mfe[0]), .m_valid(mv[0]), .m_ready(rdy[0]), .overrun(ovr[0]), .busy(bsy[0]));

    uart_rx_os #(.CLK_FREQ(CLKF), .BAUD_RATE(BAUD), .OVERSAMPLE(OS), .DATA_BITS(8),
                 .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(DEPTH)) dut_p (
        .clk(clk), .rst_n(rst_n), .rx(rx[1]), .m_data(md_p), .m_parity_err(mpe[1]),
        .m_frame_err(mfe[1]), .m_valid(mv[1]), .m_ready(rdy[1]), .overrun(ovr[1]), .busy(bsy[1]));

    uart_rx_os #(.CLK_FREQ(CLKF), .BAUD_RATE(BAUD), .OVERSAMPLE(OS), .DATA_BITS(7),
                 .PARITY(0), .STOP_BITS(2), .FIFO_DEPTH(DEPTH)) dut_s (
        .clk(clk), .rst_n(rst_n), .rx(rx[2]), .m_data(md_s), .m_parity_err(mpe[2]),
        .m_frame_err(mfe[2]), .m_valid(mv[2]), .m_ready(rdy[2]), .overrun(ovr[2]), .busy(bsy[2]));

    function automatic int db_of(int i);
        return (i == 2) ? 7 : 8;
    endfunction

    function automatic int par_of(int i);
        return (i == 1) ? 2 : 0;
    endfunction

    function automatic int sb_of(int i);
        return (i == 2) ? 2 : 1;
    endfunction

    function automatic int qsize(int i);
        case (i)
            0:       return q0.size();
            1:       return q1.size();
            default: return q2.size();
        endcase
    endfunction

    function automatic void qpush(int i, exp_t e);
        case (i)
            0:       q0.push_back(e);
            1:       q1.push_back(e);
            default: q2.push_back(e);
        endcase
    endfunction

    function automatic exp_t qpop(int i);
        case (i)
            0:       return q0.pop_front();
            1:       return q1.pop_front();
            default: return q2.pop_front();
        endcase
    endfunction

    function automatic void chk(string name, int idx, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s[%0d]: got %0h required %0h", name, idx, act, exp);
        end
    endfunction

    always @(posedge clk) begin
        #1;
        for (int i = 0; i < NI; i++) begin
            rdy[i] = rand_rdy ? ($urandom_range(0, 3) != 0) : rdy_set[i];
        end
    end

    always @(negedge clk) begin
        for (int i = 0; i < NI; i++) begin
            if (!rst_n) begin
                hold_prev[i] = 1'b0;
            end else begin
                exp_t e;
                if (ovr[i]) ovr_cnt[i]++;
                if (hold_prev[i] && mv[i]) begin
                    chk("hold_stable", i, 32'({mdata[i], mpe[i], mfe[i]}), 32'(hold_word[i]));
                end
                if (mv[i] && rdy[i]) begin
                    if (qsize(i) == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL word[%0d]: got unexpected word %0h required none", i, mdata[i]);
                    end else begin
                        e = qpop(i);
                        chk("data", i, 32'(mdata[i]), 32'(e.d));
                        chk("perr", i, 32'(mpe[i]), 32'(e.pe));
                        chk("ferr", i, 32'(mfe[i]), 32'(e.fe));
                    end
                    last_d[i]  = mdata[i];
                    last_pe[i] = mpe[i];
                    last_fe[i] = mfe[i];
                    pops[i]++;
                end
                hold_prev[i] = mv[i] && !rdy[i];
                hold_word[i] = {mdata[i], mpe[i], mfe[i]};
            end
        end
    end

    task automatic cycles(int n);
        if (n > 0) begin
            repeat (n) @(posedge clk);
            #1;
        end
    endtask

    task automatic drive_bit(int i, logic b);
        rx[i] = b;
        cycles(BIT);
    endtask

    // Model: the word a frame must yield, from the frame format rules alone.
    task automatic send_frame(int i, logic [8:0] d, logic pbit, logic stop_val);
        exp_t       e;
        logic [8:0] dm;
        logic       want_par;
        dm = d & ((9'h1 << db_of(i)) - 9'h1);
        want_par = (par_of(i) == 1) ? ~(^dm) : ^dm;
        e.d  = dm;
        e.pe = (par_of(i) != 0) && (pbit != want_par);
        e.fe = !stop_val;
        if (!rdy[i] && !rand_rdy && qsize(i) >= DEPTH) exp_ovr[i]++;
        else qpush(i, e);
        drive_bit(i, 1'b0);
        for (int k = 0; k < db_of(i); k++) drive_bit(i, dm[k]);
        if (par_of(i) != 0) drive_bit(i, pbit);
        drive_bit(i, stop_val);
        for (int k = 1; k < sb_of(i); k++) drive_bit(i, 1'b1);
        // A low stop bit must be followed by idle, otherwise no start edge exists.
        if (!stop_val) drive_bit(i, 1'b1);
    endtask

    task automatic send_rand(int i, int n);
        for (int k = 0; k < n; k++) begin
            logic [8:0] d;
            d = 9'($urandom_range(0, 511));
            send_frame(i, d, 1'($urandom_range(0, 1)), ($urandom_range(0, 5) != 0));
            cycles($urandom_range(0, 20));
        end
    endtask

    task automatic check_reset_outputs();
        for (int i = 0; i < NI; i++) begin
            chk("rst_valid", i, 32'(mv[i]), 0);
            chk("rst_data", i, 32'(mdata[i]), 0);
            chk("rst_perr", i, 32'(mpe[i]), 0);
            chk("rst_ferr", i, 32'(mfe[i]), 0);
            chk("rst_overrun", i, 32'(ovr[i]), 0);
            chk("rst_busy", i, 32'(bsy[i]), 0);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int p0;
        int n;
        for (int i = 0; i < NI; i++) begin
            rx[i] = 1'b1;
            rdy_set[i] = 1'b1;
            exp_ovr[i] = 0;
            ovr_cnt[i] = 0;
            pops[i] = 0;
            hold_prev[i] = 1'b0;
        end
        rst_n = 1'b0;
        cycles(3);
        check_reset_outputs();
        rst_n = 1'b1;
        cycles(5);

        send_frame(0, 9'h0A5, 1'b0, 1'b1);
        cycles(3);
        chk("a5_count", 0, 32'(pops[0]), 1);
        chk("a5_data", 0, 32'(last_d[0]), 32'h0A5);
        chk("a5_flags", 0, 32'({last_pe[0], last_fe[0]}), 0);

        send_frame(1, 9'h003, 1'b1, 1'b1);
        cycles(3);
        chk("par_bad_data", 1, 32'(last_d[1]), 32'h003);
        chk("par_bad_perr", 1, 32'(last_pe[1]), 1);
        send_frame(1, 9'h007, 1'b1, 1'b1);
        cycles(3);
        chk("par_ok_data", 1, 32'(last_d[1]), 32'h007);
        chk("par_ok_perr", 1, 32'(last_pe[1]), 0);

        send_frame(0, 9'h05A, 1'b0, 1'b0);
        cycles(3);
        chk("ferr_data", 0, 32'(last_d[0]), 32'h05A);
        chk("ferr_flag", 0, 32'(last_fe[0]), 1);
        send_frame(0, 9'h011, 1'b0, 1'b1);
        cycles(3);
        chk("ferr_next_data", 0, 32'(last_d[0]), 32'h011);
        chk("ferr_next_flag", 0, 32'(last_fe[0]), 0);
        chk("ferr_count", 0, 32'(pops[0]), 3);

        p0 = pops[0];
        rx[0] = 1'b0;
        cycles(5);
        rx[0] = 1'b1;
        chk("glitch_busy", 0, 32'(bsy[0]), 1);
        n = 0;
        while (bsy[0] && n < BIT) begin
            cycles(1);
            n++;
        end
        chk("glitch_idle", 0, 32'(bsy[0]), 0);
        cycles(2 * BIT);
        chk("glitch_nopush", 0, 32'(pops[0] - p0), 0);
        chk("glitch_valid", 0, 32'(mv[0]), 0);

        qpush(0, '{d: 9'h000, pe: 1'b0, fe: 1'b1});
        rx[0] = 1'b0;
        cycles(12 * BIT);
        rx[0] = 1'b1;
        cycles(2 * BIT);
        chk("break_count", 0, 32'(pops[0] - p0), 1);
        chk("break_word", 0, 32'({last_d[0], last_fe[0]}), 32'({9'h000, 1'b1}));

        rdy_set[0] = 1'b0;
        cycles(2);
        p0 = pops[0];
        for (int k = 1; k <= 5; k++) begin
            send_frame(0, 9'(k), 1'b0, 1'b1);
            if (k == 4) chk("ovr_before5", 0, 32'(ovr_cnt[0]), 0);
        end
        cycles(2);
        chk("ovr_after5", 0, 32'(ovr_cnt[0]), 1);
        chk("ovr_full_valid", 0, 32'(mv[0]), 1);
        rdy_set[0] = 1'b1;
        cycles(8);
        chk("drain_count", 0, 32'(pops[0] - p0), 4);
        chk("drain_last", 0, 32'(last_d[0]), 32'h004);
        chk("drain_valid", 0, 32'(mv[0]), 0);

        p0 = pops[2];
        drive_bit(2, 1'b0);
        drive_bit(2, 1'b1);
        drive_bit(2, 1'b0);
        drive_bit(2, 1'b1);
        chk("mid_busy", 2, 32'(bsy[2]), 1);
        rst_n = 1'b0;
        #1;
        check_reset_outputs();
        rx[2] = 1'b1;
        cycles(4);
        rst_n = 1'b1;
        cycles(4);
        send_frame(2, 9'h03F, 1'b0, 1'b1);
        cycles(3 * BIT);
        chk("rst_frame_count", 2, 32'(pops[2] - p0), 1);
        chk("rst_frame_word", 2, 32'({last_d[2], last_pe[2], last_fe[2]}), 32'({9'h03F, 2'b00}));

        rand_rdy = 1'b1;
        fork
            send_rand(0, 8);
            send_rand(1, 8);
            send_rand(2, 8);
        join
        rand_rdy = 1'b0;
        n = 0;
        while ((mv[0] || mv[1] || mv[2]) && n < 200) begin
            cycles(1);
            n++;
        end
        cycles(4);

        for (int i = 0; i < NI; i++) begin
            chk("final_pending", i, 32'(qsize(i)), 0);
            chk("final_overrun", i, 32'(ovr_cnt[i]), 32'(exp_ovr[i]));
            chk("final_valid", i, 32'(mv[i]), 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
